// File: rtl/pulse_width_stretcher_pkg.sv
// rtl/pulse_width_stretcher_pkg.sv - shared widths and state codes for pulse/strobe timing blocks
package pulse_width_stretcher_pkg;

   localparam int CNT_W  = 8;
   localparam int PEND_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_width_stretcher_if.sv
// rtl/pulse_width_stretcher_if.sv - event input and stretched-pulse status bundle
interface pulse_width_stretcher_if;
   import pulse_width_stretcher_pkg::*;

   logic              in;
   logic              out;
   logic              busy;
   logic [PEND_W-1:0] pend;
   logic              overflow;

   modport master (output in, input out, busy, pend, overflow);
   modport slave  (input in, output out, busy, pend, overflow);

endinterface

// File: rtl/stretch_counter.sv
// rtl/stretch_counter.sv - loadable down counter that parks at zero and flags it
module stretch_counter
   import pulse_width_stretcher_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_width_stretcher.sv
// rtl/pulse_width_stretcher.sv - stretches single-cycle events into WIDTH-high pulses with GAP spacing
module pulse_width_stretcher
   import pulse_width_stretcher_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int GAP    = 1,
   parameter int QDEPTH = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pulse_width_stretcher_if.slave  pws
);

   localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP - 1);
   localparam logic [PEND_W-1:0] QMAX      = PEND_W'(QDEPTH);

   state_t            state_q, state_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              out_q, out_d;
   logic              busy_q, busy_d;
   logic              overflow_q, overflow_d;

   logic              cnt_load;
   logic              cnt_en;
   logic              cnt_zero;
   logic [CNT_W-1:0]  cnt_load_value;
   logic              leave_gap;
   logic              direct;
   logic              dec;
   logic              drop;
   logic              inc;

   stretch_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .value (cnt_load_value),
      .en    (cnt_en),
      .zero  (cnt_zero)
   );

   always_comb begin
      state_d        = state_q;
      cnt_load       = 1'b0;
      cnt_en         = 1'b0;
      cnt_load_value = HIGH_LOAD;
      case (state_q)
         ST_IDLE: begin
            if (pws.in) begin
               state_d  = ST_HIGH;
               cnt_load = 1'b1;
            end
         end
         ST_HIGH: begin
            if (cnt_zero) begin
               state_d        = ST_GAP;
               cnt_load       = 1'b1;
               cnt_load_value = GAP_LOAD;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_zero) begin
               if ((pend_q != '0) || pws.in) begin
                  state_d  = ST_HIGH;
                  cnt_load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // An event that can start a pulse right away never enters the queue.
   always_comb begin
      leave_gap  = (state_q == ST_GAP) && cnt_zero;
      direct     = pws.in && ((state_q == ST_IDLE) || (leave_gap && (pend_q == '0)));
      dec        = leave_gap && (pend_q != '0);
      drop       = pws.in && (state_q != ST_IDLE) && (pend_q == QMAX) && !dec;
      inc        = pws.in && !drop && !direct;
      pend_d     = pend_q + PEND_W'(inc) - PEND_W'(dec);
      out_d      = (state_d == ST_HIGH);
      busy_d     = (state_d != ST_IDLE);
      overflow_d = drop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pend_q     <= '0;
         out_q      <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         out_q      <= out_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
      end
   end

   assign pws.out      = out_q;
   assign pws.busy     = busy_q;
   assign pws.pend     = pend_q;
   assign pws.overflow = overflow_q;

endmodule

// File: tb/tb_pulse_width_stretcher.sv
// tb/tb_pulse_width_stretcher.sv - self-checking bench for pulse_width_stretcher
module tb_pulse_width_stretcher;

   localparam int NI           = 2;
   localparam int W_A          = 4;
   localparam int G_A          = 1;
   localparam int W_B          = 1;
   localparam int G_B          = 1;
   localparam int Q_ALL        = 3;
   localparam int STRESS_START = 150;
   localparam int STRESS_LEN   = 2000;
   localparam int END_CYC      = 2200;

   localparam int S_OUT   = 0;
   localparam int S_BUSY  = 1;
   localparam int S_PEND  = 2;
   localparam int S_OVF   = 3;
   localparam int S_RISES = 4;
   localparam int S_OVFS  = 5;
   localparam int NLIT    = 49;

   // {cycle, signal, value} for instance a
   int lits [NLIT][3] = '{
      '{2, S_PEND, 0}, '{2, S_BUSY, 0},
      '{10, S_OUT, 0}, '{11, S_OUT, 1}, '{12, S_PEND, 0}, '{14, S_OUT, 1},
      '{15, S_OUT, 0}, '{15, S_BUSY, 1}, '{16, S_BUSY, 0}, '{20, S_RISES, 1},
      '{31, S_OUT, 1}, '{35, S_OUT, 0}, '{35, S_PEND, 2}, '{36, S_OUT, 1},
      '{36, S_PEND, 1}, '{40, S_OUT, 0}, '{41, S_OUT, 1}, '{46, S_BUSY, 0},
      '{46, S_PEND, 0}, '{50, S_RISES, 4}, '{50, S_OVFS, 0},
      '{64, S_PEND, 3}, '{65, S_OVF, 1}, '{66, S_OVF, 0}, '{66, S_PEND, 3},
      '{71, S_PEND, 2}, '{81, S_PEND, 0}, '{85, S_BUSY, 1}, '{86, S_BUSY, 0},
      '{90, S_RISES, 9}, '{90, S_OVFS, 1},
      '{104, S_OUT, 1}, '{105, S_OUT, 0}, '{105, S_PEND, 0}, '{106, S_OUT, 1},
      '{106, S_PEND, 0}, '{110, S_BUSY, 1}, '{111, S_BUSY, 0}, '{115, S_RISES, 11},
      '{122, S_PEND, 1}, '{122, S_BUSY, 1}, '{124, S_OUT, 0}, '{124, S_PEND, 0},
      '{131, S_OUT, 1}, '{134, S_OUT, 1}, '{135, S_OUT, 0}, '{136, S_BUSY, 0},
      '{136, S_PEND, 0}, '{140, S_RISES, 13}
   };

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   snap_t = -1;
   int   snap_v = 0;

   pulse_width_stretcher_if ifa ();
   pulse_width_stretcher_if ifb ();

   pulse_width_stretcher #(.WIDTH(W_A), .GAP(G_A), .QDEPTH(Q_ALL)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .pws   (ifa.slave)
   );

   pulse_width_stretcher #(.WIDTH(W_B), .GAP(G_B), .QDEPTH(Q_ALL)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .pws   (ifb.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic d_in   [NI];
   logic d_out  [NI];
   logic d_busy [NI];
   logic d_ovf  [NI];
   int   d_pend [NI];
   assign d_in[0]   = ifa.in;
   assign d_in[1]   = ifb.in;
   assign d_out[0]  = ifa.out;
   assign d_out[1]  = ifb.out;
   assign d_busy[0] = ifa.busy;
   assign d_busy[1] = ifb.busy;
   assign d_ovf[0]  = ifa.overflow;
   assign d_ovf[1]  = ifb.overflow;
   assign d_pend[0] = int'(ifa.pend);
   assign d_pend[1] = int'(ifb.pend);

   // Model: accepted events form a chain of starts spaced WIDTH+GAP apart
   // (mf = first start, ml = last scheduled start); outputs follow from arithmetic.
   int mv [NI], mf [NI], ml [NI], acc [NI], ovf_prev [NI];
   int rises [NI], ovfs [NI], prev_out [NI];
   int w, p, sc, e_out, e_busy, e_pend, e_ovf, active, dec, dropping;
   string nm;

   task automatic chk(input string name, input int act_v, input int exp_v);
      vectors++;
      if (act_v != exp_v) begin
         miscompares++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act_v, exp_v);
      end
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         mv[i] = 0; mf[i] = 0; ml[i] = 0; acc[i] = 0; ovf_prev[i] = 0;
         rises[i] = 0; ovfs[i] = 0; prev_out[i] = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         w  = (i == 0) ? W_A : W_B;
         p  = w + ((i == 0) ? G_A : G_B);
         nm = (i == 0) ? "a" : "b";
         dropping = 0;
         if (!rst_n) begin
            mv[i] = 0; ovf_prev[i] = 0;
            e_out = 0; e_busy = 0; e_pend = 0; e_ovf = 0;
         end else begin
            e_pend = (mv[i] != 0 && ml[i] > cyc) ? (ml[i] - cyc - 1) / p + 1 : 0;
            sc     = ml[i] - e_pend * p;
            active = (mv[i] != 0 && sc >= mf[i] && sc <= cyc) ? 1 : 0;
            e_out  = (active != 0 && cyc <= sc + w - 1) ? 1 : 0;
            e_busy = (active != 0 && cyc <= sc + p - 1) ? 1 : 0;
            e_ovf  = ovf_prev[i];
            dec    = (e_pend > 0 && ml[i] - (e_pend - 1) * p == cyc + 1) ? 1 : 0;
            dropping = (d_in[i] && e_pend == Q_ALL && dec == 0) ? 1 : 0;
         end
         chk({"out_", nm}, int'(d_out[i]), e_out);
         chk({"busy_", nm}, int'(d_busy[i]), e_busy);
         chk({"pend_", nm}, d_pend[i], e_pend);
         chk({"overflow_", nm}, int'(d_ovf[i]), e_ovf);
         if (rst_n) begin
            ovf_prev[i] = dropping;
            if (d_in[i] && dropping == 0) begin
               acc[i]++;
               if (mv[i] == 0 || cyc + 1 >= ml[i] + p) begin
                  mf[i] = cyc + 1; ml[i] = cyc + 1; mv[i] = 1;
               end else begin
                  ml[i] = ml[i] + p;
               end
            end
         end
         if (d_out[i] && prev_out[i] == 0) rises[i]++;
         if (d_ovf[i]) ovfs[i]++;
         prev_out[i] = int'(d_out[i]);
      end

      for (int k = 0; k < NLIT; k++) begin
         if (lits[k][0] == cyc) begin
            case (lits[k][1])
               S_OUT:   chk("lit_out", int'(ifa.out), lits[k][2]);
               S_BUSY:  chk("lit_busy", int'(ifa.busy), lits[k][2]);
               S_PEND:  chk("lit_pend", int'(ifa.pend), lits[k][2]);
               S_OVF:   chk("lit_overflow", int'(ifa.overflow), lits[k][2]);
               S_RISES: chk("lit_pulse_count", rises[0], lits[k][2]);
               default: chk("lit_overflow_count", ovfs[0], lits[k][2]);
            endcase
         end
      end

      if (cyc == snap_t) chk("async_reset_outputs", snap_v, 0);
      if (cyc == END_CYC - 1) chk("stress_pulses_vs_accepted", rises[1], acc[1]);
   end

   task automatic at_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_a(input int c, input int n);
      at_cycle(c);
      ifa.in = 1'b1;
      at_cycle(c + n);
      ifa.in = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      ifa.in = 1'b0;
      ifb.in = 1'b0;
      at_cycle(3);
      rst_n = 1'b1;

      pulse_a(10, 1);
      pulse_a(30, 1);
      pulse_a(32, 1);
      pulse_a(33, 1);
      pulse_a(60, 6);
      pulse_a(100, 1);
      pulse_a(105, 1);
      pulse_a(120, 3);

      // Mid-HIGH with two queued: pull reset between clock edges.
      at_cycle(123);
      #2;
      rst_n = 1'b0;
      #1;
      snap_v = int'({ifa.out, ifa.busy, ifa.pend, ifa.overflow});
      snap_t = 123;
      at_cycle(126);
      rst_n = 1'b1;
      pulse_a(130, 1);

      for (int c = STRESS_START; c < STRESS_START + STRESS_LEN; c++) begin
         at_cycle(c);
         ifb.in = ($urandom_range(0, 99) < 45);
      end
      at_cycle(STRESS_START + STRESS_LEN);
      ifb.in = 1'b0;

      at_cycle(END_CYC);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
